hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Scheduler for the decode stage. Tracks every in-flight destination register through EX, MEM and WB.
- Decides per cycle whether the instruction in decode must stall (load-use) or may issue.
- When it issues, supplies registered forwarding selects for rs1/rs2 that enter EX in lockstep with the decode output registers.
- Also keeps a saturating stall-cycle counter for performance debug.

Parameters:
- DEPTH, 3: in-flight slots (0=EX, 1=MEM, 2=WB); fixed pipeline depth behind decode.
- CNT_W, 32: width of stall counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- issue_valid  in  1  decode holds a real instruction this cycle
- rs1  in  5  source register 1 index of decoding instruction
- rs2  in  5  source register 2 index
- rs1_used  in  1  instruction reads rs1 (not PC/none)
- rs2_used  in  1  instruction reads rs2 (not imm)
- rd  in  5  destination index
- reg_write  in  1  instruction writes rd
- is_load  in  1  instruction is a memory load
- flush  in  1  branch/jump taken in EX: kill instruction in decode
- stall_out  out  1  combinational: hold fetch/decode, inject bubble
- fwd1_sel_out  out  2  registered FwdSel for rs1 in EX
- fwd2_sel_out  out  2  registered FwdSel for rs2 in EX
- stall_count_out  out  CNT_W  saturating count of stall cycles

Behaviour:
- Slot contents: valid, rd, is_load. Slot i advances to slot i+1 every cycle unconditionally; slot DEPTH-1 retires.
- Match rule: slot i matches source s when slot.valid, slot.rd == s, s != 0, s_used.
- Hazard: issue_valid & !flush & (rs1 or rs2 matches slot0 with slot0.is_load).
- stall_out = hazard. Flush never asserts stall_out.
- Issue condition: issue = issue_valid & !flush & !hazard. Next slot0 = {issue & reg_write & rd!=0, rd, is_load}; otherwise slot0 becomes invalid (bubble).
- Forward select encoding (FwdSel):
  - FWD_NONE=0
  - FWD_MEM=1: producer is now in MEM latch
  - FWD_WB=2: producer is in WB latch
  - FWD_RETIRE=3: producer writes RF this edge
- Registered forward selects, evaluated on the current slots. On issue, fwdN_sel_out <= the youngest match:
  - slot0 -> FWD_MEM
  - slot1 -> FWD_WB
  - slot2 -> FWD_RETIRE
  - none -> FWD_NONE
- Youngest match always wins (e.g. rd written in slot0 and slot2 -> FWD_MEM).
- On no-issue (stall, flush, !issue_valid), both selects <= FWD_NONE.
- Latency: stall_out same cycle; fwd selects one cycle after issue, aligned with decode output registers.
- Stall counter: +1 every cycle stall_out=1; saturates at all-ones; no wrap.
- Simultaneous flush and hazard: flush wins, stall_out=0, bubble inserted, counter unchanged.
- x0: never tracked, never forwarded, never causes stall.
- Reset (synchronous, any cycle including mid-stall):
  - all slots invalid
  - fwd1_sel_out=fwd2_sel_out=FWD_NONE
  - stall_count_out=0
  - stall_out=0 from the next cycle
- Load stall lasts exactly one cycle: after the bubble the load sits in slot1 and the consumer issues with FWD_WB.

Decomposition:
- Shared package gains:
  - typedef FwdSel (2-bit enum, values above)
  - typedef ScoreEntry (valid, RegId rd, is_load)
  - constant SCOREBOARD_DEPTH=3
- Reuses existing RegId/Bool/Clock types.
- One natural sub-module: hazard_match (combinational). Compares one source index against all slots; returns hit, youngest slot index and load-hit. Instantiated twice.

Test Plan:
- ALU dependency: issue add x5 (reg_write); next cycle issue rs1=x5 -> stall_out=0, next cycle fwd1_sel_out=FWD_MEM.
- Load-use: issue load x7; next cycle rs2=x7 rs2_used -> stall_out=1 for exactly 1 cycle; re-presented, issues with fwd2_sel_out=FWD_WB; stall_count_out=1.
- Distance 3: writer x3 then two unrelated instrs then reader x3 -> fwd1_sel_out=FWD_RETIRE; distance 4 -> FWD_NONE.
- Youngest-wins: writes x9 at t0 and t2, reader at t3 -> FWD_MEM, not FWD_RETIRE.
- x0 and unused sources: load x0 then reader x0; load x4 then reader with rs1=x4, rs1_used=0 -> no stall, FWD_NONE.
- Flush and reset:
  - flush during a load-use hazard -> stall_out=0, slot0 bubble, counter unchanged.
  - rst mid-stall -> counter 0, selects FWD_NONE, following reader of the flushed rd sees FWD_NONE.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the decode-stage hazard scoreboard:
// register ids, forwarding selects and in-flight slot entries.
package hazard_scoreboard_pkg;

  typedef logic       Bool;
  typedef logic       Clock;
  typedef logic [4:0] RegId;

  localparam int SCOREBOARD_DEPTH = 3;

  typedef enum logic [1:0] {
    FWD_NONE   = 2'd0,
    FWD_MEM    = 2'd1,
    FWD_WB     = 2'd2,
    FWD_RETIRE = 2'd3
  } FwdSel;

  typedef struct packed {
    Bool  valid;
    RegId rd;
    Bool  is_load;
  } ScoreEntry;

  // Slot index maps directly onto the stage the producer occupies next cycle.
  function automatic FwdSel to_fwd(Bool hit, logic [1:0] idx);
    if (!hit) return FWD_NONE;
    unique case (idx)
      2'd0:    return FWD_MEM;
      2'd1:    return FWD_WB;
      default: return FWD_RETIRE;
    endcase
  endfunction

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Compares one source register against every in-flight slot;
// reports the youngest matching slot and a load-in-EX hit.
module hazard_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH = SCOREBOARD_DEPTH
) (
  input  RegId                  src,
  input  logic                  used,
  input  ScoreEntry [DEPTH-1:0] slots,
  output logic                  hit,
  output logic [1:0]            idx,
  output logic                  load_hit
);

  logic live;
  assign live = used && (src != 5'd0);

  always_comb begin
    hit      = 1'b0;
    idx      = 2'd0;
    load_hit = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (live && slots[i].valid && slots[i].rd == src) begin
        hit = 1'b1;
        idx = 2'(i);
      end
    end
    load_hit = live && slots[0].valid
             && slots[0].rd == src && slots[0].is_load;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage scoreboard: load-use stall, registered
// forwarding selects and a saturating stall counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH = SCOREBOARD_DEPTH,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic [4:0]       rd,
  input  logic             reg_write,
  input  logic             is_load,
  input  logic             flush,
  output logic             stall_out,
  output logic [1:0]       fwd1_sel_out,
  output logic [1:0]       fwd2_sel_out,
  output logic [CNT_W-1:0] stall_count_out
);

  ScoreEntry [DEPTH-1:0] slots;

  logic       hit1, hit2;
  logic       ld1, ld2;
  logic [1:0] idx1, idx2;
  logic       live, hazard, issue;

  hazard_match #(.DEPTH(DEPTH)) u_m1 (
    .src      (rs1),
    .used     (rs1_used),
    .slots    (slots),
    .hit      (hit1),
    .idx      (idx1),
    .load_hit (ld1)
  );

  hazard_match #(.DEPTH(DEPTH)) u_m2 (
    .src      (rs2),
    .used     (rs2_used),
    .slots    (slots),
    .hit      (hit2),
    .idx      (idx2),
    .load_hit (ld2)
  );

  // Flush outranks the hazard so a killed instruction never stalls.
  assign live      = issue_valid && !flush;
  assign hazard    = live && (ld1 || ld2);
  assign issue     = live && !hazard;
  assign stall_out = hazard;

  always_ff @(posedge clk) begin
    if (rst) begin
      slots <= '0;
    end else begin
      slots[0] <= '{valid:   issue && reg_write && (rd != 5'd0),
                    rd:      rd,
                    is_load: is_load};
      for (int i = 1; i < DEPTH; i++)
        slots[i] <= slots[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd1_sel_out <= FWD_NONE;
      fwd2_sel_out <= FWD_NONE;
    end else if (issue) begin
      fwd1_sel_out <= to_fwd(hit1, idx1);
      fwd2_sel_out <= to_fwd(hit2, idx2);
    end else begin
      fwd1_sel_out <= FWD_NONE;
      fwd2_sel_out <= FWD_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_count_out <= '0;
    else if (stall_out && stall_count_out != {CNT_W{1'b1}})
      stall_count_out <= stall_count_out + 1'b1;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; narrow counter
// so saturation is reachable.
module tb_hazard_scoreboard;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic [4:0]    rs1, rs2, rd;
  logic          rs1_used, rs2_used;
  logic          reg_write, is_load, flush;
  logic          stall_out;
  logic [1:0]    fwd1_sel_out, fwd2_sel_out;
  logic [CW-1:0] stall_count_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.DEPTH(3), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .issue_valid     (issue_valid),
    .rs1             (rs1),
    .rs2             (rs2),
    .rs1_used        (rs1_used),
    .rs2_used        (rs2_used),
    .rd              (rd),
    .reg_write       (reg_write),
    .is_load         (is_load),
    .flush           (flush),
    .stall_out       (stall_out),
    .fwd1_sel_out    (fwd1_sel_out),
    .fwd2_sel_out    (fwd2_sel_out),
    .stall_count_out (stall_count_out)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(logic v, logic [4:0] s1, logic u1,
                       logic [4:0] s2, logic u2, logic [4:0] d,
                       logic w, logic ld, logic fl);
    issue_valid = v;
    rs1 = s1; rs1_used = u1;
    rs2 = s2; rs2_used = u2;
    rd = d; reg_write = w; is_load = ld; flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  // writer: rd with reg_write; nop: valid, writes nothing
  task automatic wr(logic [4:0] d, logic ld);
    drive(1, 0, 0, 0, 0, d, 1, ld, 0);
  endtask

  task automatic nop();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    chk("rst_fwd1", fwd1_sel_out, 0);
    chk("rst_fwd2", fwd2_sel_out, 0);
    chk("rst_cnt", stall_count_out, 0);
    chk("rst_stall", stall_out, 0);

    // ALU dependency -> MEM
    wr(5, 0); tick();
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
    chk("alu_stall", stall_out, 0);
    tick();
    chk("alu_fwd1", fwd1_sel_out, 1);
    chk("alu_fwd2", fwd2_sel_out, 0);
    idle(3);

    // load-use: one stall, then WB
    wr(7, 1); tick();
    drive(1, 0, 0, 7, 1, 0, 0, 0, 0);
    chk("lu_stall", stall_out, 1);
    tick();
    chk("lu_bubble_fwd2", fwd2_sel_out, 0);
    chk("lu_stall2", stall_out, 0);
    tick();
    chk("lu_fwd2", fwd2_sel_out, 2);
    chk("lu_cnt", stall_count_out, 1);
    idle(3);

    // distance 3 -> RETIRE
    wr(3, 0); tick();
    nop(); tick();
    nop(); tick();
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0); tick();
    chk("d3_fwd1", fwd1_sel_out, 3);
    idle(3);

    // distance 4 -> NONE
    wr(3, 0); tick();
    nop(); tick();
    nop(); tick();
    nop(); tick();
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0); tick();
    chk("d4_fwd1", fwd1_sel_out, 0);
    idle(3);

    // youngest wins
    wr(9, 0); tick();
    nop(); tick();
    wr(9, 0); tick();
    drive(1, 9, 1, 9, 1, 0, 0, 0, 0); tick();
    chk("yw_fwd1", fwd1_sel_out, 1);
    chk("yw_fwd2", fwd2_sel_out, 1);
    idle(3);

    // x0 never tracked
    wr(0, 1); tick();
    drive(1, 0, 1, 0, 1, 0, 0, 0, 0);
    chk("x0_stall", stall_out, 0);
    tick();
    chk("x0_fwd1", fwd1_sel_out, 0);
    chk("x0_fwd2", fwd2_sel_out, 0);
    idle(3);

    // unused source never matches
    wr(4, 1); tick();
    drive(1, 4, 0, 0, 0, 0, 0, 0, 0);
    chk("unused_stall", stall_out, 0);
    tick();
    chk("unused_fwd1", fwd1_sel_out, 0);
    idle(3);

    // rs1 load-use also stalls
    wr(12, 1); tick();
    drive(1, 12, 1, 0, 0, 0, 0, 0, 0);
    chk("lu1_stall", stall_out, 1);
    tick(); tick();
    chk("lu1_fwd1", fwd1_sel_out, 2);
    chk("lu1_cnt", stall_count_out, 2);
    idle(3);

    // flush beats hazard; flushed rd=10 load is a bubble
    wr(6, 1); tick();
    drive(1, 6, 1, 0, 0, 10, 1, 1, 1);
    chk("fl_stall", stall_out, 0);
    tick();
    chk("fl_cnt", stall_count_out, 2);
    chk("fl_fwd1", fwd1_sel_out, 0);
    drive(1, 10, 1, 0, 0, 0, 0, 0, 0);
    chk("fl_bubble_stall", stall_out, 0);
    tick();
    chk("fl_bubble_fwd1", fwd1_sel_out, 0);
    idle(3);

    // reset in the middle of a stall
    wr(8, 1); tick();
    drive(1, 0, 0, 8, 1, 0, 0, 0, 0);
    chk("rs_stall", stall_out, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rs_cnt", stall_count_out, 0);
    chk("rs_fwd2", fwd2_sel_out, 0);
    chk("rs_stall_after", stall_out, 0);
    tick();
    chk("rs_reader_fwd2", fwd2_sel_out, 0);
    chk("rs_cnt2", stall_count_out, 0);
    idle(3);

    // counter saturates at all-ones
    for (int k = 1; k <= 4; k++) begin
      wr(7, 1); tick();
      drive(1, 0, 0, 7, 1, 0, 0, 0, 0);
      chk("sat_stall", stall_out, 1);
      tick(); tick();
      chk("sat_cnt", stall_count_out, (k > 3) ? 3 : k);
      idle(3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
